// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shifts and a
// shift-add multiply, with results registered behind a valid/ready output.
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_illegal
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam int CW = SHW + 1;

    logic [1:0]       state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    // Single-cycle datapath, evaluated on the request operands
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;
    logic [WIDTH:0]   sum_w;
    logic [SHW-1:0]   amt;
    logic             is_shift;

    assign amt      = in_b[SHW-1:0];
    assign is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        sum_w   = '0;
        case (in_op)
            4'd0: begin
                sum_w   = {1'b0, in_a} + {1'b0, in_b};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            4'd1: begin
                sum_w   = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            4'd2:    alu_res = ~in_a;
            4'd3:    alu_res = in_a & in_b;
            4'd4:    alu_res = in_a | in_b;
            4'd5:    alu_res = in_a ^ in_b;
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
            4'd8, 4'd9, 4'd10: alu_res = in_a;  // only reached with amount 0
            4'd11:   alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One iteration: a 1-bit shift, or one shift-add multiply step on {hi,lo}
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_c;
    logic [WIDTH:0]   msum;

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        step_c  = 1'b0;
        msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        case (op_q)
            OP_SLL: {step_c, step_hi} = {hi_q, 1'b0};
            OP_SRL: {step_hi, step_c} = {1'b0, hi_q};
            OP_SRA: {step_hi, step_c} = {hi_q[WIDTH-1], hi_q};
            default: begin
                step_hi = msum[WIDTH:1];
                step_lo = {msum[0], lo_q[WIDTH-1:1]};
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: if (in_valid && rdy_q) begin
                op_d  = in_op;
                opa_d = in_a;
                hi_d  = (in_op == OP_MUL) ? '0 : in_a;
                lo_d  = in_b;
                if (in_op == OP_MUL) begin
                    cnt_d   = CW'(WIDTH);
                    state_d = S_EXEC;
                end else if (is_shift && amt != '0) begin
                    cnt_d   = CW'(amt);
                    state_d = S_EXEC;
                end else begin
                    state_d = S_DONE;
                    res_d   = alu_res;
                    zero_d  = (alu_res == '0);
                    carry_d = alu_c;
                    ovf_d   = alu_v;
                    ill_d   = alu_ill;
                end
            end
            S_EXEC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    res_d   = (op_q == OP_MUL) ? step_lo : step_hi;
                    zero_d  = (((op_q == OP_MUL) ? step_lo : step_hi) == '0);
                    carry_d = (op_q == OP_MUL) ? (|step_hi) : step_c;
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            op_q    <= '0;
            opa_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready     = rdy_q;
    assign out_valid    = (state_q == S_DONE);
    assign out_res      = res_q;
    assign out_zero     = zero_q;
    assign out_carry    = carry_q;
    assign out_overflow = ovf_q;
    assign out_illegal  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed checks of alu_seq at WIDTH=4 and WIDTH=8 against hand-computed results.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_ready = 1'b0;
    logic [3:0] in_op = '0;

    logic       iv4 = 1'b0, ir4, ov4, z4, c4, v4, il4;
    logic [3:0] a4 = '0, b4 = '0, r4;
    logic       iv8 = 1'b0, ir8, ov8, z8, c8, v8, il8;
    logic [7:0] a8 = '0, b8 = '0, r8;

    int nvec = 0, nerr = 0, lat = 0;
    logic [7:0] g_res;
    logic       g_z, g_c, g_v, g_il;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_op(in_op),
        .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(out_ready), .out_res(r4),
        .out_zero(z4), .out_carry(c4), .out_overflow(v4), .out_illegal(il4));

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_op(in_op),
        .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(out_ready), .out_res(r8),
        .out_zero(z8), .out_carry(c8), .out_overflow(v8), .out_illegal(il8));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Present one request, let it be accepted, then scramble the inputs.
    task automatic start(input bit w8, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_op = op;
        if (w8) begin a8 = a; b8 = b; iv8 = 1'b1; end
        else    begin a4 = a[3:0]; b4 = b[3:0]; iv4 = 1'b1; end
        @(posedge clk); #1;
        iv4 = 1'b0; iv8 = 1'b0;
        a8 = ~a; b8 = ~b; a4 = ~a[3:0]; b4 = ~b[3:0]; in_op = ~op;
        @(negedge clk);
        lat = 1;
    endtask

    task automatic wait_res(input bit w8);
        while (!(w8 ? ov8 : ov4) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!(w8 ? ov8 : ov4)) begin
            nvec++; nerr++;
            $display("FAIL timeout waiting for out_valid");
        end
        g_res = w8 ? r8 : {4'b0, r4};
        g_z   = w8 ? z8 : z4;
        g_c   = w8 ? c8 : c4;
        g_v   = w8 ? v8 : v4;
        g_il  = w8 ? il8 : il4;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state and release
        #12;
        chk("rst_out", {ov4, r4, z4, c4, v4, il4, ov8, r8, z8, c8, v8, il8}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rdy_pre", {ir4, ir8}, 2'b00);
        @(negedge clk);
        chk("rdy_post", {ir4, ir8}, 2'b11);
        repeat (3) @(negedge clk);
        chk("idle_noval", {ov4, ov8}, 2'b00);

        // WIDTH=4 arithmetic
        start(0, 4'd0, 8'd7, 8'd1); wait_res(0);
        chk("add7_1", {g_res, g_z, g_c, g_v, g_il}, {8'h08, 4'b0010});
        chk("add_lat", lat, 1);
        ack();
        chk("rdy_after_ack", {ir4, ov4}, 2'b10);
        start(0, 4'd0, 8'd15, 8'd1); wait_res(0);
        chk("add15_1", {g_res, g_z, g_c, g_v, g_il}, {8'h00, 4'b1100});
        ack();
        start(0, 4'd1, 8'd3, 8'd5); wait_res(0);
        chk("sub3_5", {g_res, g_z, g_c, g_v, g_il}, {8'h0E, 4'b0000});
        ack();
        start(0, 4'd6, 8'b1110, 8'b0001); wait_res(0);
        chk("slt", {g_res, g_z, g_c, g_v}, {8'h01, 3'b000});
        ack();
        start(0, 4'd7, 8'd9, 8'd9); wait_res(0);
        chk("eq", {g_res, g_z}, {8'h01, 1'b0});
        ack();
        start(0, 4'd5, 8'b1010, 8'b1010); wait_res(0);
        chk("xor_zero", {g_res, g_z}, {8'h00, 1'b1});
        ack();

        // WIDTH=8 multiply; a second request during EXEC must be ignored
        start(1, 4'd11, 8'd200, 8'd3);
        chk("mul_busy0", ir8, 1'b0);
        in_op = 4'd0; a8 = 8'd1; b8 = 8'd1; iv8 = 1'b1;
        @(negedge clk); lat++;
        iv8 = 1'b0;
        chk("mul_busy1", ir8, 1'b0);
        wait_res(1);
        chk("mul", {g_res, g_z, g_c, g_v, g_il}, {8'h58, 4'b0100});
        chk("mul_lat", lat, 9);
        ack();
        repeat (2) @(negedge clk);
        chk("no_extra", {ov8, ir8}, 2'b01);
        start(1, 4'd11, 8'd15, 8'd17); wait_res(1);
        chk("mul_small", {g_res, g_c}, {8'hFF, 1'b0});
        ack();

        // WIDTH=8 shifts
        start(1, 4'd10, 8'h80, 8'd3); wait_res(1);
        chk("sra", {g_res, g_z, g_c}, {8'hF0, 2'b00});
        chk("sra_lat", lat, 4);
        ack();
        start(1, 4'd8, 8'h81, 8'd1); wait_res(1);
        chk("sll", {g_res, g_c}, {8'h02, 1'b1});
        chk("sll_lat", lat, 2);
        ack();
        start(1, 4'd9, 8'h0B, 8'd2); wait_res(1);
        chk("srl", {g_res, g_c}, {8'h02, 1'b1});
        ack();
        start(1, 4'd9, 8'h5A, 8'd0); wait_res(1);
        chk("shift0", {g_res, g_c}, {8'h5A, 1'b0});
        chk("shift0_lat", lat, 1);
        ack();

        // Backpressure: outputs hold while out_ready is low
        start(0, 4'd0, 8'd7, 8'd1); wait_res(0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {ov4, ir4, r4, z4, c4, v4, il4}, {2'b10, 4'h8, 4'b0010});
            @(negedge clk);
        end
        ack();

        // Reset in the middle of a multiply
        start(1, 4'd11, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_mid", {ov8, ir8, r8, z8, c8, v8, il8}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ov8) chk("rst_no_result", ov8, 1'b0);
        end
        chk("rst_idle", {ov8, ir8}, 2'b01);

        // Illegal opcode
        start(0, 4'd13, 8'd5, 8'd6); wait_res(0);
        chk("illegal", {g_res, g_z, g_c, g_v, g_il}, {8'h00, 4'b1001});
        chk("ill_lat", lat, 1);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the team's 4-bit combinational ALU.
- Keeps the eight basic ops on opcodes 0-7: add, sub, not, and, or, xor, signed less-than, equal.
- Adds iterative multi-cycle shifts and an unsigned shift-add multiply on extended opcodes.
- Sits between the decode stage and writeback in npc. Results and flags are registered behind a valid/ready output handshake.

Parameters:
- WIDTH, 4: operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  4  opcode (see Behaviour).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_res  output  WIDTH  result.
- out_zero  output  1  out_res == 0.
- out_carry  output  1  carry flag.
- out_overflow  output  1  signed overflow flag.
- out_illegal  output  1  opcode was 12-15.

Behaviour:
- Reset: asynchronous on rst_n low; state IDLE; all outputs and internal registers 0. in_ready rises the first cycle after rst_n deasserts.
- Reset mid-operation: the in-flight op is dropped with no output.
- States: IDLE, EXEC, DONE.
  - in_ready = (state == IDLE). No new request is accepted in EXEC or DONE.
  - Accept: in_valid && in_ready on a rising edge. Operands and opcode are latched there; later input changes have no effect.
- Single-cycle ops (0-7, 12-15, and shifts with amount 0):
  - Result computed at accept.
  - IDLE -> DONE; out_valid high the next cycle (latency 1).
- Multi-cycle ops: IDLE -> EXEC.
  - Shifts: amount = in_b[SHW-1:0]; one bit position per cycle. EXEC lasts amount cycles, then -> DONE.
  - Multiply: EXEC lasts exactly WIDTH cycles, then -> DONE.
- DONE:
  - Outputs held stable while out_valid && !out_ready.
  - On out_ready: -> IDLE and out_valid drops next cycle. Throughput is at most one op per 2 cycles.
- Opcodes and flags. Unless stated, carry = overflow = 0.
  - 0 add: {carry,res} = a + b; overflow = (a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
  - 1 sub: res = a + ~b + 1; carry = carry-out of that sum (1 = no borrow); overflow = (a[MSB]!=b[MSB]) && (res[MSB]!=a[MSB]).
  - 2 not: res = ~a.
  - 3 and: a & b.
  - 4 or: a | b.
  - 5 xor: a ^ b.
  - 6 slt: res = {0..., signed(a) < signed(b)}.
  - 7 eq: res = {0..., a == b}.
  - 8 sll by amount.
  - 9 srl by amount.
  - 10 sra by amount (sign-filled).
  - Shift carry: the last bit shifted out (0 if amount 0).
  - 11 mul: res = low WIDTH bits of unsigned a*b; carry = 1 iff the high WIDTH bits are nonzero.
  - 12-15: res = 0, illegal = 1, zero = 1, latency 1.
- out_zero always reflects the final out_res.
- Flags, out_illegal and out_res update only on entry to DONE.

Test Plan:
- WIDTH=4, reset release: after rst_n 0->1, in_ready=1 next cycle; all outputs 0; out_valid stays 0 with no request.
- WIDTH=4, add 7+1 -> res=8, overflow=1, carry=0, out_valid 1 cycle after accept. Add 15+1 -> res=0, carry=1, zero=1.
- WIDTH=4, sub 3-5 -> res=14, carry=0. slt a=1110 b=0001 -> res=1. eq 9,9 -> res=1.
- WIDTH=8, mul 200*3 -> res=0x58, carry=1, out_valid 9 cycles after accept. in_ready=0 throughout; a second in_valid is ignored.
- WIDTH=8:
  - sra 0x80 by 3 -> 0xF0, carry=0, latency 4.
  - sll 0x81 by 1 -> 0x02, carry=1.
  - shift by 0 -> res=a, latency 1.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Assert rst_n=0 mid-mul -> immediate IDLE, all outputs 0, no result emitted. Opcode 13 -> illegal=1, res=0.
